// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the nRisc core: BOOT/FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory-ready handshake and timeout, terminal HALT/ERR states and a retired-instruction counter.
module controle_multiciclo #(
  parameter int OPW         = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   instr_op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             jump,
  output logic             branch,
  output logic             ler_mem,
  output logic             escreve_mem,
  output logic             op_ula,
  output logic             memto_reg,
  output logic             defi,
  output logic             ula_src,
  output logic             escreve_reg,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

  localparam logic [2:0] OP_DEFI = 3'b000;
  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SUBI = 3'b101;
  localparam logic [2:0] OP_J    = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] instr_count_q;
  logic             illegal_q;
  logic             timeout_q;

  // Opcode bits above [2:0] only exist for wider IR encodings; any set bit is illegal.
  logic op_upper_nz;
  if (OPW > 3) begin : g_upper
    assign op_upper_nz = |instr_op[OPW-1:3];
  end else begin : g_no_upper
    assign op_upper_nz = 1'b0;
  end

  logic tmo_hit;
  assign tmo_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                   (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      op_q          <= '0;
      wait_cnt_q    <= '0;
      instr_count_q <= '0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q    <= S_FETCH;
          wait_cnt_q <= '0;
        end
        S_FETCH: begin
          if (mem_ready) begin
            state_q    <= S_DECODE;
            wait_cnt_q <= '0;
          end else if (tmo_hit) begin
            state_q   <= S_ERR;
            timeout_q <= 1'b1;
          end else if (MEM_TIMEOUT != 0) begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          op_q <= instr_op[2:0];
          if (instr_op[2:0] == OP_HALT && !op_upper_nz) begin
            state_q <= S_HALT;
          end else if (op_upper_nz) begin
            state_q   <= S_ERR;
            illegal_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          wait_cnt_q <= '0;
          case (op_q)
            OP_LW, OP_SW:    state_q <= S_MEM;
            OP_MUL, OP_SUBI: state_q <= S_WB;
            default: begin
              state_q       <= S_FETCH;
              instr_count_q <= sat_inc(instr_count_q);
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            wait_cnt_q <= '0;
            if (op_q == OP_LW) begin
              state_q <= S_WB;
            end else begin
              state_q       <= S_FETCH;
              instr_count_q <= sat_inc(instr_count_q);
            end
          end else if (tmo_hit) begin
            state_q   <= S_ERR;
            timeout_q <= 1'b1;
          end else if (MEM_TIMEOUT != 0) begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        S_WB: begin
          state_q       <= S_FETCH;
          wait_cnt_q    <= '0;
          instr_count_q <= sat_inc(instr_count_q);
        end
        default: ;
      endcase
    end
  end

  // Strobes are Moore on state/op, except the FETCH handshake and the beq condition.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    ler_mem     = 1'b0;
    escreve_mem = 1'b0;
    op_ula      = 1'b0;
    memto_reg   = 1'b0;
    defi        = 1'b0;
    ula_src     = 1'b0;
    escreve_reg = 1'b0;
    case (state_q)
      S_FETCH: begin
        ler_mem  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        case (op_q)
          OP_DEFI: begin
            defi        = 1'b1;
            escreve_reg = 1'b1;
          end
          OP_BEQ: begin
            ula_src  = 1'b1;
            branch   = 1'b1;
            pc_write = zero;
          end
          OP_MUL: begin
            op_ula  = 1'b1;
            ula_src = 1'b1;
          end
          OP_J: begin
            jump     = 1'b1;
            pc_write = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ler_mem     = (op_q == OP_LW);
        escreve_mem = (op_q == OP_SW);
      end
      S_WB: begin
        escreve_reg = 1'b1;
        memto_reg   = (op_q == OP_LW);
        op_ula      = (op_q == OP_MUL);
        ula_src     = (op_q == OP_MUL);
      end
      default: ;
    endcase
  end

  assign halted      = (state_q == S_HALT);
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign state_o     = state_q;
  assign instr_count = instr_count_q;

endmodule
